// File: rtl/chip_cycle.sv
// chip_cycle: YM2203 x2 / SAA1099 access cycle former; SAA path enabled by SAA1099_EN
module chip_cycle #(
  parameter int CNT_W     = 5,
  parameter int YM_SETUP  = 1,
  parameter int YM_PULSE  = 15,
  parameter int SAA_SETUP = 3,
  parameter int SAA_PULSE = 7,
  parameter int HOLD      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wraddr_on,
  input  logic       wrdata_on,
  input  logic       rddata_on,
  input  logic [1:0] sel,
  output logic [1:0] ym_cs_n,
  output logic       ym_wr_n,
  output logic       ym_rd_n,
  output logic       ym_a0,
  output logic       saa_cs_n,
  output logic       saa_wr_n,
  output logic       saa_a0,
  output logic       dq_oe,
  output logic       rd_le,
  output logic       rd_oe,
  output logic       busy
);
  localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_STROBE = 3'd2, S_HOLD = 3'd3, S_RELEASE = 3'd4;
  localparam logic [1:0] K_ADDR = 2'd0, K_DATA = 2'd1, K_READ = 2'd2;
`ifdef SAA1099_EN
  localparam logic SAA_EN = 1'b1;
`else
  localparam logic SAA_EN = 1'b0;
`endif
  logic [2:0] state, n_state;
  logic [CNT_W-1:0] cnt, n_cnt;
  logic [1:0] kind, n_kind, sel_q, n_sel;
  logic req, ym, saa, act, n_read;
  // next state, counter and latched request; outputs are derived from these and registered
  always_comb begin
    req = wraddr_on | wrdata_on | rddata_on;
    n_kind = state == S_IDLE ? (wraddr_on ? K_ADDR : wrdata_on ? K_DATA : K_READ) : kind;
    n_sel = state == S_IDLE ? sel : sel_q;
    n_read = n_kind == K_READ;
    ym = !n_sel[1];
    saa = SAA_EN && n_sel == 2'b10 && !n_read;
    n_state = state;
    n_cnt = cnt == '0 ? cnt : cnt - CNT_W'(1);
    case (state)
      S_IDLE: if (req) begin
        n_state = ym || saa ? S_SETUP : S_RELEASE;
        n_cnt = ym ? CNT_W'(YM_SETUP - 1) : saa ? CNT_W'(SAA_SETUP - 1) : '0;
      end
      S_SETUP: if (cnt == '0) begin
        n_state = S_STROBE;
        n_cnt = ym ? CNT_W'(YM_PULSE - 1) : CNT_W'(SAA_PULSE - 1);
      end
      S_STROBE: if (cnt == '0) begin
        n_state = S_HOLD;
        n_cnt = CNT_W'(HOLD - 1);
      end
      S_HOLD: if (cnt == '0) begin
        n_state = S_RELEASE;
        n_cnt = '0;
      end
      S_RELEASE: n_state = req ? S_RELEASE : S_IDLE;
      default: begin
        n_state = S_IDLE;
        n_cnt = '0;
      end
    endcase
    act = n_state == S_SETUP || n_state == S_STROBE || n_state == S_HOLD;
  end
  // state and registered chip-side strobes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      kind <= K_ADDR;
      sel_q <= 2'b11;
      ym_cs_n <= 2'b11;
      ym_wr_n <= 1'b1;
      ym_rd_n <= 1'b1;
      ym_a0 <= 1'b0;
      saa_cs_n <= 1'b1;
      saa_wr_n <= 1'b1;
      saa_a0 <= 1'b0;
      dq_oe <= 1'b0;
      rd_le <= 1'b0;
      rd_oe <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= n_state;
      cnt <= n_cnt;
      kind <= n_kind;
      sel_q <= n_sel;
      ym_cs_n <= ~{act && ym && n_sel[0], act && ym && !n_sel[0]};
      ym_wr_n <= !(n_state == S_STROBE && ym && !n_read);
      ym_rd_n <= !(n_state == S_STROBE && ym && n_read);
      ym_a0 <= act && ym && n_kind != K_ADDR;
      saa_cs_n <= !(act && saa);
      saa_wr_n <= !(n_state == S_STROBE && saa);
      saa_a0 <= act && saa && n_kind == K_ADDR;
      dq_oe <= act && !n_read;
      rd_le <= n_state == S_STROBE && ym && n_read;
      rd_oe <= n_state != S_IDLE && ym && n_read && rddata_on;
      busy <= n_state != S_IDLE;
    end
endmodule

// File: tb/tb_chip_cycle.sv
// tb_chip_cycle: directed checks of chip_cycle timing, priority, null cycles and reset
module tb_chip_cycle;
  logic clk = 1'b0, rst = 1'b1;
  logic wraddr_on = 1'b0, wrdata_on = 1'b0, rddata_on = 1'b0;
  logic [1:0] sel = 2'b11;
  logic [1:0] ym_cs_n;
  logic ym_wr_n, ym_rd_n, ym_a0, saa_cs_n, saa_wr_n, saa_a0, dq_oe, rd_le, rd_oe, busy;
  logic [11:0] obs;
  int n_chk = 0, n_fail = 0;
  chip_cycle dut (
    .clk(clk), .rst(rst), .wraddr_on(wraddr_on), .wrdata_on(wrdata_on), .rddata_on(rddata_on),
    .sel(sel), .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n), .ym_rd_n(ym_rd_n), .ym_a0(ym_a0),
    .saa_cs_n(saa_cs_n), .saa_wr_n(saa_wr_n), .saa_a0(saa_a0), .dq_oe(dq_oe),
    .rd_le(rd_le), .rd_oe(rd_oe), .busy(busy)
  );
  always #5 clk = ~clk;
  assign obs = {ym_cs_n, ym_wr_n, ym_rd_n, ym_a0, saa_cs_n, saa_wr_n, saa_a0, dq_oe, rd_le, rd_oe, busy};
  function automatic logic [11:0] mk(input logic [1:0] cs, input logic wr, rd, a0, scs, swr, sa0, dq, le, oe, bz);
    return {cs, wr, rd, a0, scs, swr, sa0, dq, le, oe, bz};
  endfunction
  function automatic logic inr(input int k, lo, hi);
    return k >= lo && k <= hi;
  endfunction
  task automatic check(input string tag, input logic [11:0] got, exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic ym_addr_wr(input string tag, input int last);
    sel = 2'b00;
    wraddr_on = 1'b1;
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      check($sformatf("%s_%0d", tag, k), obs,
            mk(inr(k, 1, 17) ? 2'b10 : 2'b11, !inr(k, 2, 16), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
               inr(k, 1, 17), 1'b0, 1'b0, inr(k, 1, 18)));
      if (k == 10) wraddr_on = 1'b0;
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("reset", obs, mk(2'b11, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    rst = 1'b0;
    @(negedge clk);
    check("idle", obs, mk(2'b11, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    ym_addr_wr("t1", 20);
    sel = 2'b01;
    rddata_on = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      @(negedge clk);
      check($sformatf("t2_%0d", k), obs,
            mk(inr(k, 1, 17) ? 2'b01 : 2'b11, 1'b1, !inr(k, 2, 16), inr(k, 1, 17), 1'b1, 1'b1, 1'b0,
               1'b0, inr(k, 2, 16), inr(k, 1, 40), inr(k, 1, 40)));
      if (k == 40) rddata_on = 1'b0;
    end
    sel = 2'b10;
    wrdata_on = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
`ifdef SAA1099_EN
      check($sformatf("t3_%0d", k), obs,
            mk(2'b11, 1'b1, 1'b1, 1'b0, !inr(k, 1, 11), !inr(k, 4, 10), 1'b0,
               inr(k, 1, 11), 1'b0, 1'b0, inr(k, 1, 12)));
`else
      check($sformatf("t3_%0d", k), obs,
            mk(2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, inr(k, 1, 8)));
`endif
      if (k == 8) wrdata_on = 1'b0;
    end
    sel = 2'b00;
    wraddr_on = 1'b1;
    wrdata_on = 1'b1;
    for (int k = 1; k <= 104; k++) begin
      @(negedge clk);
      check($sformatf("t4_%0d", k), obs,
            mk(inr(k, 1, 17) ? 2'b10 : 2'b11, !inr(k, 2, 16), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0,
               inr(k, 1, 17), 1'b0, 1'b0, inr(k, 1, 100)));
      if (k == 100) begin
        wraddr_on = 1'b0;
        wrdata_on = 1'b0;
      end
    end
    ym_addr_wr("t5a", 6);
    rst = 1'b1;
    wraddr_on = 1'b0;
    #1;
    check("t5_rst", obs, mk(2'b11, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ym_addr_wr("t5b", 20);
    sel = 2'b11;
    wrdata_on = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check($sformatf("t6_%0d", k), obs,
            mk(2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, inr(k, 1, 5)));
      if (k == 5) wrdata_on = 1'b0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
